// File: rtl/piso_tx_ctrl_pkg.sv
// Shared types and helpers for the PISO transmit controller.
package piso_tx_ctrl_pkg;

  // Controller states: waiting for a word, or pacing a word out
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit-counter width for an n-bit word; never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_tx_ctrl_shift_reg.sv
// n-bit register with parallel load, clear and shift-right (zero fill).
module shift_reg_univ #(
  parameter int unsigned n = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         clr,
  input  logic         shift,
  input  logic [n-1:0] d,
  output logic         sout
);

  logic [n-1:0] q;

  // Load wins over clear, clear wins over shift
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (clr) begin
      q <= '0;
    end else if (shift) begin
      q <= {1'b0, q[n-1:1]};
    end
  end

  assign sout = q[0];

endmodule

// File: rtl/piso_tx_ctrl.sv
// PISO transmit controller: valid/ready word intake, LSB-first serial pacing.
module piso_tx_ctrl
  import piso_tx_ctrl_pkg::*;
#(
  parameter int unsigned n = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [n-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         tx_en,
  output logic         sout,
  output logic         sout_valid,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CW = cnt_width(n);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_bit;
  logic          accept;
  logic          sr_shift;
  logic          sr_clr;

  // Last bit of the current word is being consumed at this edge
  assign last_bit = (state == SHIFT) & tx_en & (cnt == CW'(n - 1));
  assign in_ready = (state == IDLE) | last_bit;
  assign accept   = in_valid & in_ready;
  assign sr_shift = (state == SHIFT) & tx_en & ~last_bit;
  assign sr_clr   = last_bit & ~in_valid;

  // State, bit index and end-of-word pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            state <= SHIFT;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          if (tx_en) begin
            if (cnt == CW'(n - 1)) begin
              done <= 1'b1;
              cnt  <= '0;
              if (!in_valid) begin
                state <= IDLE;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy       = (state == SHIFT);
  assign sout_valid = (state == SHIFT);

  shift_reg_univ #(.n(n)) u_sr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (accept),
    .clr     (sr_clr),
    .shift   (sr_shift),
    .d       (in_data),
    .sout    (sout)
  );

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Scoreboard bench for piso_tx_ctrl with n=4.
module tb_piso_tx_ctrl;

  localparam int unsigned N = 4;

  logic         clk;
  logic         reset_n;
  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         tx_en;
  logic         sout;
  logic         sout_valid;
  logic         busy;
  logic         done;

  typedef struct {
    logic b;
    logic last;
  } exp_bit_t;

  exp_bit_t exp_q[$];
  logic     exp_done;
  int       n_tests;
  int       n_fail;

  piso_tx_ctrl #(.n(N)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx_en      (tx_en),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: inputs are stable at the falling edge, so this sees what the next rising edge will act on
  always @(negedge clk) begin
    logic live;
    logic rdy;
    if (!reset_n) begin
      exp_q.delete();
      exp_done = 1'b0;
    end else begin
      live = (exp_q.size() != 0);
      check("done", 32'(done), 32'(exp_done));
      check("sout_valid", 32'(sout_valid), 32'(live));
      check("busy", 32'(busy), 32'(live));
      exp_done = 1'b0;
      if (live) begin
        check("sout", 32'(sout), 32'(exp_q[0].b));
        rdy = tx_en & exp_q[0].last;
        if (tx_en) begin
          exp_done = exp_q[0].last;
          void'(exp_q.pop_front());
        end
      end else begin
        check("sout_idle", 32'(sout), 32'd0);
        rdy = 1'b1;
      end
      check("in_ready", 32'(in_ready), 32'(rdy));
      if (in_valid && rdy) begin
        for (int i = 0; i < N; i++) begin
          exp_bit_t e;
          e.b    = in_data[i];
          e.last = (i == N - 1);
          exp_q.push_back(e);
        end
      end
    end
  end

  initial begin
    logic [6:0] pace;
    bit         drained;
    n_tests  = 0;
    n_fail   = 0;
    exp_done = 1'b0;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    tx_en    = 1'b0;

    // Reset values, including across a rising edge with in_valid asserted
    #3;
    check("rst_sout", 32'(sout), 32'd0);
    check("rst_sout_valid", 32'(sout_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = 4'hC;
    step();
    step();
    check("rst_nocapture", 32'(sout_valid), 32'd0);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    repeat (3) step();

    // Single word, tx_en held high
    in_data  = 4'b1011;
    in_valid = 1'b1;
    tx_en    = 1'b1;
    step();
    in_valid = 1'b0;
    in_data  = '0;
    repeat (6) step();

    // Pacing with tx_en 1,0,0,1,1,0,1
    in_data  = 4'b1011;
    in_valid = 1'b1;
    tx_en    = 1'b0;
    step();
    in_valid = 1'b0;
    pace = 7'b1011001;
    for (int i = 0; i < 7; i++) begin
      tx_en = pace[i];
      step();
    end
    tx_en = 1'b0;
    repeat (3) step();

    // Back-to-back A then 5 with in_valid held
    in_data  = 4'hA;
    in_valid = 1'b1;
    tx_en    = 1'b1;
    step();
    in_data = 4'h5;
    repeat (4) step();
    in_valid = 1'b0;
    repeat (6) step();

    // Backpressure: offered word changes every cycle while busy
    in_data  = 4'h3;
    in_valid = 1'b1;
    tx_en    = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      in_data = N'($urandom);
      tx_en   = (i != 1);
      step();
    end
    in_valid = 1'b0;
    repeat (6) step();

    // Mid-word reset after two bits
    in_data  = 4'h6;
    in_valid = 1'b1;
    tx_en    = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    #2 reset_n = 1'b0;
    #1;
    check("mrst_sout", 32'(sout), 32'd0);
    check("mrst_sout_valid", 32'(sout_valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = 4'h9;
    step();
    step();
    check("mrst_nocapture", 32'(busy), 32'd0);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    step();
    in_data  = 4'hF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (6) step();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = N'($urandom);
      tx_en    = ($urandom_range(0, 3) != 0);
      step();
    end

    // Bounded drain
    in_valid = 1'b0;
    tx_en    = 1'b1;
    drained  = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (exp_q.size() == 0 && !busy) begin
        drained = 1'b1;
        break;
      end
    end
    check("drain", 32'(drained), 32'd1);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
